// File: rtl/spi_ram_responder.sv
// SPI mode-0 serial SRAM responder (READ 0x03 / WRITE 0x02, sequential mode).
// SPI pins are oversampled in the clk domain; a backdoor port reads and writes the byte array.
module spi_ram_responder #(
    parameter int ADDR_BITS  = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_clk,
    input  logic                  spi_select,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  busy,
    input  logic                  bd_we,
    input  logic [DEPTH_LOG2-1:0] bd_addr,
    input  logic [7:0]            bd_wdata,
    output logic [7:0]            bd_rdata
);
    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_RD,
        ST_WR,
        ST_IGNORE
    } state_t;

    state_t state_q, state_d;

    logic sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
    logic sel_meta_q, sel_meta_d, sel_sync_q, sel_sync_d;
    logic mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;

    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [6:0]           shift_q, shift_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 is_write_q, is_write_d;
    logic [7:0]           tx_q, tx_d;
    logic                 miso_q, miso_d;

    logic [7:0] mem [DEPTH];

    logic                  sck_rise, sck_fall, sel_active, last_bit;
    logic [7:0]            rx_byte;
    logic [ADDR_BITS-1:0]  addr_shifted, addr_inc;
    logic                  spi_we;
    logic [DEPTH_LOG2-1:0] spi_waddr;
    logic [7:0]            spi_wdata;

    // Synchronisers: MOSI runs through the same depth as SCK so they stay aligned.
    always_comb begin
        sck_meta_d  = spi_clk;
        sck_sync_d  = sck_meta_q;
        sck_prev_d  = sck_sync_q;
        sel_meta_d  = spi_select;
        sel_sync_d  = sel_meta_q;
        mosi_meta_d = spi_mosi;
        mosi_sync_d = mosi_meta_q;
    end

    // NOTE: clocked blocks use <= so every flop samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            sel_meta_q  <= 1'b1;
            sel_sync_q  <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sck_meta_q  <= sck_meta_d;
            sck_sync_q  <= sck_sync_d;
            sck_prev_q  <= sck_prev_d;
            sel_meta_q  <= sel_meta_d;
            sel_sync_q  <= sel_sync_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign sck_rise     = sck_sync_q & ~sck_prev_q;
    assign sck_fall     = ~sck_sync_q & sck_prev_q;
    assign sel_active   = ~sel_sync_q;
    assign last_bit     = (bit_cnt_q == 3'd7);
    assign rx_byte      = {shift_q, mosi_sync_q};
    assign addr_shifted = {addr_q[ADDR_BITS-2:0], mosi_sync_q};
    assign addr_inc     = addr_q + ADDR_BITS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!sel_active) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_CMD;
                ST_CMD: begin
                    if (sck_rise && last_bit) begin
                        if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
                            state_d = ST_ADDR_HI;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_HI: begin
                    if (sck_rise && last_bit) state_d = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    if (sck_rise && last_bit) state_d = is_write_q ? ST_WR : ST_RD;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        is_write_d = is_write_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        spi_we     = 1'b0;
        spi_waddr  = addr_q[DEPTH_LOG2-1:0];
        spi_wdata  = rx_byte;
        if (!sel_active) begin
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_d = 3'd0;
                    miso_d    = 1'b0;
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) is_write_d = (rx_byte == CMD_WRITE);
                    end
                end
                ST_ADDR_HI, ST_ADDR_LO: begin
                    if (sck_rise) begin
                        addr_d    = addr_shifted;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        // Preload the first read byte so the next falling edge can drive bit 7.
                        if (state_q == ST_ADDR_LO && last_bit) begin
                            tx_d = mem[addr_shifted[DEPTH_LOG2-1:0]];
                        end
                    end
                end
                ST_RD: begin
                    if (sck_fall) begin
                        miso_d    = tx_q[7];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            addr_d = addr_inc;
                            tx_d   = mem[addr_inc[DEPTH_LOG2-1:0]];
                        end else begin
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                ST_WR: begin
                    if (sck_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            spi_we = 1'b1;
                            addr_d = addr_inc;
                        end
                    end
                end
                ST_IGNORE: miso_d = 1'b0;
                default:   miso_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            addr_q     <= '0;
            is_write_q <= 1'b0;
            tx_q       <= 8'd0;
            miso_q     <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            is_write_q <= is_write_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
        end
    end

    // NOTE: the array has no reset; it behaves as SRAM and contents survive rst_n.
    // The SPI write comes last so it wins a same-byte collision with the backdoor.
    always_ff @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_wdata;
        if (spi_we) mem[spi_waddr] <= spi_wdata;
    end

    assign bd_rdata = mem[bd_addr];
    assign spi_miso = miso_q;
    assign busy     = sel_active;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Bench for spi_ram_responder: directed scenarios plus random frames checked
// against a plain byte-array model of the memory.
module tb_spi_ram_responder;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst_n, spi_clk, spi_select, spi_mosi, spi_miso, busy, bd_we;
    logic [7:0] bd_addr, bd_wdata, bd_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_mem [256];
    logic [7:0] wr_buf [4];
    bit in_frame   = 1'b0;
    bit watch_miso = 1'b0;
    int busy_drops = 0;
    int miso_highs = 0;

    spi_ram_responder #(.ADDR_BITS(16), .DEPTH_LOG2(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_select(spi_select),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .busy      (busy),
        .bd_we     (bd_we),
        .bd_addr   (bd_addr),
        .bd_wdata  (bd_wdata),
        .bd_rdata  (bd_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (in_frame && busy !== 1'b1) busy_drops++;
        if (watch_miso && spi_miso !== 1'b0) miso_highs++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sck_cycle(input logic mosi_bit, output logic miso_bit);
        spi_mosi = mosi_bit;
        repeat (HALF) @(negedge clk);
        miso_bit = spi_miso;
        spi_clk  = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            sck_cycle(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic frame_start();
        @(negedge clk);
        spi_select = 1'b0;
        repeat (4) @(negedge clk);
        in_frame = 1'b1;
    endtask

    task automatic frame_end();
        in_frame = 1'b0;
        repeat (2) @(negedge clk);
        spi_select = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we    = 1'b1;
        bd_addr  = a;
        bd_wdata = d;
        @(negedge clk);
        bd_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic bd_check(input string tag, input logic [7:0] a);
        @(negedge clk);
        bd_addr = a;
        #1;
        check(tag, 32'(bd_rdata), 32'(model_mem[a]));
    endtask

    task automatic compare_all(input string tag);
        int bad = 0;
        for (int a = 0; a < 256; a++) begin
            bd_addr = 8'(a);
            #1;
            if (bd_rdata !== model_mem[a]) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic spi_read_check(input string tag, input logic [15:0] addr, input int n);
        logic [7:0] rx;
        logic [7:0] idx;
        frame_start();
        xfer(8'h03, rx);
        xfer(addr[15:8], rx);
        xfer(addr[7:0], rx);
        for (int k = 0; k < n; k++) begin
            xfer(8'h00, rx);
            idx = addr[7:0] + 8'(k);
            check($sformatf("%s[%0d]", tag, k), 32'(rx), 32'(model_mem[idx]));
        end
        frame_end();
    endtask

    // Writes wr_buf[0..n-1]; the last byte is checked on the backdoor 5 clk after its 8th SCK rise.
    task automatic spi_write(input string tag, input logic [15:0] addr, input int n);
        logic [7:0] rx;
        logic [7:0] idx;
        frame_start();
        xfer(8'h02, rx);
        xfer(addr[15:8], rx);
        xfer(addr[7:0], rx);
        idx = addr[7:0];
        for (int k = 0; k < n; k++) begin
            idx = addr[7:0] + 8'(k);
            bd_addr = idx;
            xfer(wr_buf[k], rx);
            model_mem[idx] = wr_buf[k];
        end
        @(negedge clk);
        #1;
        check({tag, "_latency"}, 32'(bd_rdata), 32'(model_mem[idx]));
        frame_end();
    endtask

    initial begin
        logic [7:0]  rx;
        logic        b;
        logic [15:0] ra;
        int          n;

        rst_n      = 1'b0;
        spi_clk    = 1'b0;
        spi_select = 1'b0;
        spi_mosi   = 1'b0;
        bd_we      = 1'b0;
        bd_addr    = 8'h00;
        bd_wdata   = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_miso", 32'(spi_miso), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        spi_select = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int a = 0; a < 256; a++) bd_write(8'(a), 8'($urandom));
        bd_check("bd_fill_07", 8'h07);
        bd_check("bd_fill_c8", 8'hC8);

        // Basic read of a backdoor-written byte; busy must hold for the whole frame
        bd_write(8'h10, 8'h5A);
        spi_read_check("t1_read", 16'h0010, 1);
        check("t1_busy_held", 32'(busy_drops), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);

        // Two-byte sequential write; neighbour untouched
        bd_write(8'h22, 8'h77);
        wr_buf[0] = 8'hA5;
        wr_buf[1] = 8'h3C;
        spi_write("t2_write", 16'h0020, 2);
        bd_check("t2_mem20", 8'h20);
        bd_check("t2_mem21", 8'h21);
        bd_check("t2_mem22", 8'h22);

        // Read across the top of the array wraps to address 0
        bd_write(8'hFE, 8'h11);
        bd_write(8'hFF, 8'h22);
        spi_read_check("t3_wrap", 16'h00FE, 3);

        // Partial byte aborted by deselect is not written
        bd_write(8'h30, 8'h00);
        frame_start();
        xfer(8'h02, rx);
        xfer(8'h00, rx);
        xfer(8'h30, rx);
        for (int i = 0; i < 5; i++) sck_cycle(1'b1, b);
        frame_end();
        bd_check("t4_partial", 8'h30);
        spi_read_check("t4_next_read", 16'h0030, 1);

        // Unknown command is ignored
        bd_write(8'h00, 8'hC3);
        miso_highs = 0;
        frame_start();
        watch_miso = 1'b1;
        xfer(8'h9F, rx);
        xfer(8'h00, rx);
        xfer(8'h00, rx);
        xfer(8'hFF, rx);
        check("t5_rx0", 32'(rx), 32'd0);
        xfer(8'hFF, rx);
        check("t5_rx1", 32'(rx), 32'd0);
        watch_miso = 1'b0;
        frame_end();
        check("t5_miso_quiet", 32'(miso_highs), 32'd0);
        compare_all("t5_mem_intact");
        spi_read_check("t5_next_read", 16'h0000, 2);

        // Reset in the middle of a read
        bd_write(8'h40, 8'hFF);
        frame_start();
        xfer(8'h03, rx);
        xfer(8'h00, rx);
        xfer(8'h40, rx);
        for (int i = 0; i < 3; i++) sck_cycle(1'b0, b);
        check("t6_bit_before_reset", 32'(b), 32'd1);
        in_frame = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("t6_reset_miso", 32'(spi_miso), 32'd0);
        check("t6_reset_busy", 32'(busy), 32'd0);
        spi_select = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bd_check("t6_mem_kept", 8'h40);
        spi_read_check("t6_after_reset", 16'h0040, 2);

        // Random frames, including aliased upper address bits and wrap-around
        for (int t = 0; t < 10; t++) begin
            ra = 16'($urandom);
            n  = int'($urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 4; k++) wr_buf[k] = 8'($urandom);
                spi_write($sformatf("rnd%0d_wr", t), ra, n);
            end else begin
                spi_read_check($sformatf("rnd%0d_rd", t), ra, n);
            end
        end
        compare_all("final_mem");
        check("final_busy_held", 32'(busy_drops), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
